serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
- Parametrised bit-serial N-bit adder: one full-adder cell plus a carry flip-flop, processing one bit per clock, LSB first.
- Next-generation arithmetic block after the single-bit gate-level full adder. Trades latency (WIDTH cycles) for area.
- Start/busy/done handshake. Produces sum, carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- ready  output  1  high in IDLE and DONE; start accepted
- busy  output  1  high in ADD
- done  output  1  single-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow = carry into MSB XOR cout

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE
  - sum=0, cout=0, overflow=0, done=0, busy=0, ready=1
  - internal shift registers, carry FF and counter cleared
- Reset takes priority over every other event, including mid-ADD. Any in-flight operation is discarded and no done pulse is issued.
- FSM states:
  - IDLE:
    - start=1 -> load a_sh<=a, b_sh<=b, c<=cin, cnt<=0; go to ADD.
    - Otherwise stay.
  - ADD, each edge:
    - s_bit = a_sh[0]^b_sh[0]^c; c <= majority(a_sh[0],b_sh[0],c).
    - s_sh shifts right with s_bit entering at MSB; a_sh and b_sh shift right; cnt++.
    - At cnt==WIDTH-2, latch c_msb <= carry into MSB (the carry value used for bit WIDTH-1 on the next edge).
    - When cnt==WIDTH-1 (last bit): go to DONE and update the outputs:
      - sum <= {s_bit, s_sh[WIDTH-1:1]}
      - cout <= final carry
      - overflow <= c_in_msb ^ final carry
  - DONE:
    - One cycle only; done=1.
    - start=1 -> accepted exactly as in IDLE (back-to-back), go to ADD.
    - Otherwise go to IDLE.
- Latency: start accepted at edge k -> outputs updated at edge k+WIDTH, done high during the cycle after edge k+WIDTH. Throughput is one add per WIDTH+1 cycles back-to-back.
- Outputs sum/cout/overflow change only at completion edges. They hold their value through subsequent IDLE and ADD cycles until the next completion.
- start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- a/b/cin may change freely after acceptance; only values at the accepted edge matter.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned. overflow interprets a, b, sum as two's complement.
- busy, ready and done are decoded from registered state (Moore outputs).

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants (IDLE=2'd0, ADD=2'd1, DONE=2'd2)
  - WIDTH range-check constants MIN_W=2, MAX_W=64
- One natural sub-module: fa_cell, a combinational gate-level full adder (sum=a^b^c, cout=ab|bc|ac) instantiated once in the datapath.
- FSM, counter and shift registers stay in serial_adder_n.

Test Plan:
- WIDTH=8, rst for 2 cycles, then idle -> sum=0x00, cout=0, overflow=0, ready=1, busy=0, done=0.
- start with a=0xFF, b=0x01, cin=0 at edge k -> busy for edges k+1..k+8, done in cycle after edge k+8; sum=0x00, cout=1, overflow=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. Then a=0xFF, b=0xFF, cin=1 issued in the done cycle (back-to-back) -> sum=0xFF, cout=1, overflow=0, done exactly 9 cycles later.
- a=0x12, b=0x34 started, then start pulsed with a=0xAA, b=0x55 during busy -> second request ignored; result sum=0x46, cout=0; no extra done pulse.
- a=0x80, b=0x80 started, rst asserted at 4th ADD cycle -> no done pulse, all outputs 0, ready=1 next cycle; a subsequent 0x03+0x04 gives 0x07.
- WIDTH=2 and WIDTH=16 builds: 1000 random a/b/cin operations each, compared against a+b+cin and the signed-overflow model; every done follows its start by exactly WIDTH+1 cycles.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the legal operand-width range.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MIN_W = 2;
  localparam int MAX_W = 64;

endpackage

// File: rtl/fa_cell.sv
// Gate-level one-bit full adder; the only arithmetic cell of the serial adder.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_b & i_c) | (i_a & i_c);

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, one bit
// per clock, LSB first, with a start/busy/done handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; ready=1
// ST_ADD  | shifting one bit per clock through the full adder; busy=1
// ST_DONE | one-cycle result strobe; done=1, ready=1 (back-to-back start ok)
module serial_adder_n
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(WIDTH - 2);

  generate
    if (WIDTH < MIN_W || WIDTH > MAX_W) begin : g_bad_width
      $error("serial_adder_n: WIDTH out of range");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 partial-sum bits need storage; the final bit is
  // taken straight from the adder on the completion edge.
  logic [WIDTH-2:0] r_s_sh;
  logic             r_c;
  logic             r_c_msb;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s_bit;
  logic             w_c_nxt;
  logic [WIDTH-1:0] w_s_cat;
  logic             w_accept;
  logic             w_last;

  fa_cell u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_c),
    .o_s (w_s_bit),
    .o_c (w_c_nxt)
  );

  assign w_s_cat  = {w_s_bit, r_s_sh};
  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = (r_state == ST_ADD) && (r_cnt == LAST_CNT);

  // State register; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_ADD;
      ST_ADD:  if (r_cnt == LAST_CNT) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_ADD : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore handshake outputs decoded from the registered state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      ST_IDLE: ready = 1'b1;
      ST_ADD:  busy  = 1'b1;
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, serial shift/carry, and result update on the
  // last bit. Results hold between completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_c     <= 1'b0;
      r_c_msb <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_c    <= cin;
      r_cnt  <= '0;
    end else if (r_state == ST_ADD) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_cat[WIDTH-1:1];
      r_c    <= w_c_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == PEN_CNT) r_c_msb <= w_c_nxt;
      if (w_last) begin
        r_sum  <= w_s_cat;
        r_cout <= w_c_nxt;
        r_ovf  <= r_c_msb ^ w_c_nxt;
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st2, c2, rdy2, bsy2, dn2, co2, ov2;
  logic [1:0]  a2, b2, s2;
  logic        st8, c8, rdy8, bsy8, dn8, co8, ov8;
  logic [7:0]  a8, b8, s8;
  logic        st16, c16, rdy16, bsy16, dn16, co16, ov16;
  logic [15:0] a16, b16, s16;

  serial_adder_n #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .cin(c2),
    .ready(rdy2), .busy(bsy2), .done(dn2), .sum(s2), .cout(co2), .overflow(ov2));
  serial_adder_n #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(c8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .sum(s8), .cout(co8), .overflow(ov8));
  serial_adder_n #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(c16),
    .ready(rdy16), .busy(bsy16), .done(dn16), .sum(s16), .cout(co16), .overflow(ov16));

  int checks = 0;
  int errors = 0;
  logic [63:0] h_sum [3];
  logic        h_cout [3];
  logic        h_ov [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input int w);
    return (w == 2) ? 0 : (w == 8) ? 1 : 2;
  endfunction

  function automatic logic [63:0] o_sum(input int w);
    case (w)
      2:       return 64'(s2);
      8:       return 64'(s8);
      default: return 64'(s16);
    endcase
  endfunction

  // {ready, busy, done, cout, overflow}
  function automatic logic [4:0] o_flags(input int w);
    case (w)
      2:       return {rdy2, bsy2, dn2, co2, ov2};
      8:       return {rdy8, bsy8, dn8, co8, ov8};
      default: return {rdy16, bsy16, dn16, co16, ov16};
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [63:0] av,
                       input logic [63:0] bv, input logic cv);
    case (w)
      2:       begin st2 = st;  a2 = av[1:0];  b2 = bv[1:0];  c2 = cv;  end
      8:       begin st8 = st;  a8 = av[7:0];  b8 = bv[7:0];  c8 = cv;  end
      default: begin st16 = st; a16 = av[15:0]; b16 = bv[15:0]; c16 = cv; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic cv, output logic [63:0] es, output logic ec,
                       output logic eo);
    logic [63:0] m;
    logic [63:0] am, bm;
    logic [64:0] tot;
    longint sa, sb, ss, lim;
    m   = (64'(1) << w) - 64'(1);
    am  = av & m;
    bm  = bv & m;
    tot = 65'(am) + 65'(bm) + 65'(cv);
    es  = tot[63:0] & m;
    ec  = tot[w];
    sa  = am[w-1] ? longint'(am) - (longint'(1) << w) : longint'(am);
    sb  = bm[w-1] ? longint'(bm) - (longint'(1) << w) : longint'(bm);
    ss  = sa + sb + longint'(cv);
    lim = longint'(1) << (w - 1);
    eo  = (ss >= lim) || (ss < -lim);
  endtask

  // Issue one add on the given width, optionally pulsing a stray start at
  // post-accept cycle inj. Returns in the done cycle with results checked.
  task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic cv, input string tag, input int inj);
    logic [63:0] es;
    logic        ec, eo;
    logic [4:0]  f;
    int          n, nbusy;
    bit          seen;
    model(w, av, bv, cv, es, ec, eo);
    drive(w, 1'b1, av, bv, cv);
    tick();
    f = o_flags(w);
    nbusy = f[3] ? 1 : 0;
    chk({tag, " hold_sum"}, o_sum(w), h_sum[idx(w)]);
    chk({tag, " hold_cout"}, 64'(f[1]), 64'(h_cout[idx(w)]));
    n = 0;
    seen = 0;
    while (!seen && n < w + 4) begin
      drive(w, (n == inj), 64'hAA ^ av, 64'h55 ^ bv, ~cv);
      tick();
      n++;
      f = o_flags(w);
      if (f[2]) seen = 1;
      else if (f[3]) nbusy++;
    end
    chk({tag, " latency"}, 64'(n), 64'(w));
    chk({tag, " busy_cycles"}, 64'(nbusy), 64'(w));
    chk({tag, " sum"}, o_sum(w), es);
    chk({tag, " cout"}, 64'(f[1]), 64'(ec));
    chk({tag, " overflow"}, 64'(f[0]), 64'(eo));
    chk({tag, " ready_busy"}, 64'(f[4:3]), 64'(2'b10));
    drive(w, 1'b0, 64'h0, 64'h0, 1'b0);
    h_sum[idx(w)]  = es;
    h_cout[idx(w)] = ec;
    h_ov[idx(w)]   = eo;
  endtask

  task automatic clear_held();
    for (int i = 0; i < 3; i++) begin
      h_sum[i] = '0; h_cout[i] = 1'b0; h_ov[i] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [4:0] f;
    rst = 1'b1;
    drive(2, 0, 0, 0, 0);
    drive(8, 0, 0, 0, 0);
    drive(16, 0, 0, 0, 0);
    clear_held();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset w2 flags", 64'(o_flags(2)), 64'(5'b10000));
    chk("reset w8 flags", 64'(o_flags(8)), 64'(5'b10000));
    chk("reset w8 sum", o_sum(8), 64'h00);
    chk("reset w16 flags", 64'(o_flags(16)), 64'(5'b10000));

    do_op(8, 64'hFF, 64'h01, 1'b0, "ff+01", -1);
    chk("ff+01 lit", 64'({o_sum(8), o_flags(8)}), 64'({64'h00, 5'b10110}));
    tick();
    chk("done single pulse", 64'(o_flags(8)), 64'(5'b10010));

    do_op(8, 64'h7F, 64'h01, 1'b0, "7f+01", -1);
    chk("7f+01 lit", 64'({o_sum(8), o_flags(8)}), 64'({64'h80, 5'b10101}));
    do_op(8, 64'hFF, 64'hFF, 1'b1, "b2b ff+ff+1", -1);
    chk("b2b lit", 64'({o_sum(8), o_flags(8)}), 64'({64'hFF, 5'b10110}));

    do_op(8, 64'h12, 64'h34, 1'b0, "ignored start", 2);
    chk("ignored lit", o_sum(8), 64'h46);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_flags(8)[2]) ndone++;
    end
    chk("no extra done", 64'(ndone), 64'(0));
    chk("sum held idle", o_sum(8), 64'h46);

    drive(8, 1'b1, 64'h80, 64'h80, 1'b0);
    tick();
    drive(8, 1'b0, 64'h80, 64'h80, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_held();
    chk("midreset flags", 64'(o_flags(8)), 64'(5'b10000));
    chk("midreset sum", o_sum(8), 64'h00);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_flags(8)[2]) ndone++;
    end
    chk("midreset no done", 64'(ndone), 64'(0));
    do_op(8, 64'h03, 64'h04, 1'b0, "03+04", -1);
    chk("03+04 lit", o_sum(8), 64'h07);

    for (int w = 2; w <= 16; w += 14) begin
      for (int i = 0; i < 1000; i++) begin
        do_op(w, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
              (w == 2) ? "rnd w2" : "rnd w16", -1);
        if ($urandom_range(1) == 1) begin
          tick();
          f = o_flags(w);
          chk((w == 2) ? "rnd w2 idle" : "rnd w16 idle", 64'(f[4:2]), 64'(3'b100));
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
